// File: rtl/mc_ctrl_seq.sv
// Multicycle MIPS control sequencer: a registered state machine with memory wait states,
// optional ADDI/BNE decode, illegal-opcode flagging and a retired-instruction counter.
module mc_ctrl_seq #(
   parameter int unsigned CNT_W  = 32,
   parameter bit          EN_IMM = 1'b1,
   parameter bit          EN_BNE = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             pc_write_cond_ne,
   output logic             iord,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic             reg_write,
   output logic             reg_dst,
   output logic [1:0]       pc_source,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_IEXEC  = 4'd10,
      S_IWB    = 4'd11,
      S_IDLE   = 4'd15
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;

   logic op_lw, op_sw, op_r, op_beq, op_bne, op_j, op_addi, op_legal;

   // Disabled optional opcodes decode as nothing, so they fall through to illegal.
   assign op_lw    = (opcode == 6'b100011);
   assign op_sw    = (opcode == 6'b101011);
   assign op_r     = (opcode == 6'b000000);
   assign op_beq   = (opcode == 6'b000100);
   assign op_bne   = EN_BNE && (opcode == 6'b000101);
   assign op_j     = (opcode == 6'b000010);
   assign op_addi  = EN_IMM && (opcode == 6'b001000);
   assign op_legal = op_lw | op_sw | op_r | op_beq | op_bne | op_j | op_addi;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (op_lw || op_sw)        state_d = S_MEMADR;
            else if (op_r)             state_d = S_EXEC;
            else if (op_beq || op_bne) state_d = S_BRANCH;
            else if (op_j)             state_d = S_JUMP;
            else if (op_addi)          state_d = S_IEXEC;
            else                       state_d = S_FETCH;
         end
         S_MEMADR: state_d = op_sw ? S_MEMWR : S_MEMRD;
         S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  state_d = S_FETCH;
         S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   state_d = S_RWB;
         S_RWB:    state_d = S_FETCH;
         S_BRANCH: state_d = S_FETCH;
         S_JUMP:   state_d = S_FETCH;
         S_IEXEC:  state_d = S_IWB;
         S_IWB:    state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retired_d = retired_q;
      if ((state_q == S_MEMWB) || (state_q == S_RWB) || (state_q == S_BRANCH) ||
          (state_q == S_JUMP) || (state_q == S_IWB) || ((state_q == S_MEMWR) && mem_ready))
         retired_d = retired_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
      end
   end

   always_comb begin
      pc_write         = 1'b0;
      pc_write_cond    = 1'b0;
      pc_write_cond_ne = 1'b0;
      iord             = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      ir_write         = 1'b0;
      mem_to_reg       = 1'b0;
      alu_src_a        = 1'b0;
      reg_write        = 1'b0;
      reg_dst          = 1'b0;
      pc_source        = 2'b00;
      alu_op           = 2'b00;
      alu_src_b        = 2'b00;
      illegal_op       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b  = 2'b11;
            illegal_op = ~op_legal;
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
         end
         S_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a        = 1'b1;
            alu_op           = 2'b01;
            pc_source        = 2'b01;
            pc_write_cond    = op_beq;
            pc_write_cond_ne = op_bne;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_IEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_IWB: reg_write = 1'b1;
         default: ;
      endcase
   end

   assign state   = state_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Self-checking bench for mc_ctrl_seq: two configurations, each driven by instruction-level
// transactions whose expected per-cycle trace is built from the instruction class and wait counts.
module tb_mc_ctrl_seq;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_BNE = 4, K_J = 5, K_ADDI = 6, K_ILL = 7;

   localparam logic [17:0] C_PCW  = 18'h20000;
   localparam logic [17:0] C_PCC  = 18'h10000;
   localparam logic [17:0] C_PCN  = 18'h08000;
   localparam logic [17:0] C_IORD = 18'h04000;
   localparam logic [17:0] C_MRD  = 18'h02000;
   localparam logic [17:0] C_MWR  = 18'h01000;
   localparam logic [17:0] C_IRW  = 18'h00800;
   localparam logic [17:0] C_M2R  = 18'h00400;
   localparam logic [17:0] C_ASA  = 18'h00200;
   localparam logic [17:0] C_RW   = 18'h00100;
   localparam logic [17:0] C_RD   = 18'h00080;
   localparam logic [17:0] C_ILL  = 18'h00001;

   typedef struct packed {
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [17:0] ctl;
      logic [31:0] ret;
   } ent_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rstn_a = 1'b0, rstn_b = 1'b0;
   logic [5:0] op_a = '0, op_b = '0;
   logic       mr_a = 1'b0, mr_b = 1'b0;

   logic pcw_a, pcc_a, pcn_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, asa_a, rw_a, rd_a, ill_a;
   logic [1:0] ps_a, aop_a, asb_a;
   logic [3:0] st_a;
   logic [31:0] ret_a;
   logic pcw_b, pcc_b, pcn_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, asa_b, rw_b, rd_b, ill_b;
   logic [1:0] ps_b, aop_b, asb_b;
   logic [3:0] st_b;
   logic [3:0] ret_b;

   logic [17:0] ctl_a, ctl_b;
   assign ctl_a = {pcw_a, pcc_a, pcn_a, iord_a, mrd_a, mwr_a, irw_a, m2r_a, asa_a, rw_a, rd_a,
                   ps_a, aop_a, asb_a, ill_a};
   assign ctl_b = {pcw_b, pcc_b, pcn_b, iord_b, mrd_b, mwr_b, irw_b, m2r_b, asa_b, rw_b, rd_b,
                   ps_b, aop_b, asb_b, ill_b};

   mc_ctrl_seq u_dut_a (
      .clk(clk), .reset_n(rstn_a), .opcode(op_a), .mem_ready(mr_a),
      .pc_write(pcw_a), .pc_write_cond(pcc_a), .pc_write_cond_ne(pcn_a),
      .iord(iord_a), .mem_read(mrd_a), .mem_write(mwr_a), .ir_write(irw_a),
      .mem_to_reg(m2r_a), .alu_src_a(asa_a), .reg_write(rw_a), .reg_dst(rd_a),
      .pc_source(ps_a), .alu_op(aop_a), .alu_src_b(asb_a), .state(st_a),
      .illegal_op(ill_a), .retired(ret_a)
   );

   mc_ctrl_seq #(.CNT_W(4), .EN_IMM(1'b0), .EN_BNE(1'b0)) u_dut_b (
      .clk(clk), .reset_n(rstn_b), .opcode(op_b), .mem_ready(mr_b),
      .pc_write(pcw_b), .pc_write_cond(pcc_b), .pc_write_cond_ne(pcn_b),
      .iord(iord_b), .mem_read(mrd_b), .mem_write(mwr_b), .ir_write(irw_b),
      .mem_to_reg(m2r_b), .alu_src_a(asa_b), .reg_write(rw_b), .reg_dst(rd_b),
      .pc_source(ps_b), .alu_op(aop_b), .alu_src_b(asb_b), .state(st_b),
      .illegal_op(ill_b), .retired(ret_b)
   );

   int n_cmp = 0;
   int n_mis = 0;
   int unsigned ret_m [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [17:0] f_ps(input logic [1:0] v);  return {11'b0, v, 5'b0}; endfunction
   function automatic logic [17:0] f_aop(input logic [1:0] v); return {13'b0, v, 3'b0}; endfunction
   function automatic logic [17:0] f_asb(input logic [1:0] v); return {15'b0, v, 1'b0}; endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] rop();
      return 6'($urandom_range(0, 63));
   endfunction

   function automatic ent_t mk(input logic [5:0] op, input logic mr, input logic [3:0] st,
                               input logic [17:0] ctl, input logic [31:0] ret);
      ent_t e;
      e.op = op; e.mr = mr; e.st = st; e.ctl = ctl; e.ret = ret;
      return e;
   endfunction

   // Instance A has ADDI/BNE enabled; instance B has both disabled.
   function automatic int classify(input logic [5:0] op, input int sel);
      case (op)
         OP_LW:   return K_LW;
         OP_SW:   return K_SW;
         OP_R:    return K_R;
         OP_BEQ:  return K_BEQ;
         OP_BNE:  return (sel == 0) ? K_BNE : K_ILL;
         OP_J:    return K_J;
         OP_ADDI: return (sel == 0) ? K_ADDI : K_ILL;
         default: return K_ILL;
      endcase
   endfunction

   task automatic drive(input int sel, input logic [5:0] op, input logic mr);
      if (sel == 0) begin op_a = op; mr_a = mr; end
      else          begin op_b = op; mr_b = mr; end
   endtask

   task automatic compare(input int sel, input ent_t e, input string tag);
      logic [3:0]  st;
      logic [17:0] ctl;
      logic [31:0] ret, exp_ret;
      if (sel == 0) begin st = st_a; ctl = ctl_a; ret = ret_a; exp_ret = e.ret; end
      else begin st = st_b; ctl = ctl_b; ret = {28'b0, ret_b}; exp_ret = e.ret & 32'hF; end
      check({tag, ".state"},   {28'b0, st},   {28'b0, e.st});
      check({tag, ".ctl"},     {14'b0, ctl},  {14'b0, e.ctl});
      check({tag, ".retired"}, ret,           exp_ret);
   endtask

   task automatic do_reset(input int sel);
      ent_t z;
      z = mk(6'b0, 1'b1, 4'd15, 18'b0, 32'b0);
      @(negedge clk);
      if (sel == 0) rstn_a = 1'b0; else rstn_b = 1'b0;
      drive(sel, rop(), 1'b1);
      #1;
      compare(sel, z, $sformatf("%s.rst_assert", sel == 0 ? "A" : "B"));
      ret_m[sel] = 0;
      @(negedge clk);
      drive(sel, rop(), 1'b1);
      #1;
      compare(sel, z, $sformatf("%s.rst_hold", sel == 0 ? "A" : "B"));
      if (sel == 0) rstn_a = 1'b1; else rstn_b = 1'b1;
   endtask

   // One instruction: w1 fetch wait cycles, w2 memory wait cycles; cut>0 plays only that many cycles.
   task automatic run_instr(input int sel, input logic [5:0] op, input int unsigned w1,
                            input int unsigned w2, input int unsigned cut);
      ent_t q[$];
      int k;
      int unsigned n;
      logic [31:0] r;
      k = classify(op, sel);
      r = ret_m[sel];
      for (int unsigned i = 0; i < w1; i++) q.push_back(mk(rop(), 1'b0, 4'd0, C_MRD | f_asb(2'b01), r));
      q.push_back(mk(rop(), 1'b1, 4'd0, C_MRD | f_asb(2'b01) | C_IRW | C_PCW, r));
      q.push_back(mk(op, rbit(), 4'd1, f_asb(2'b11) | ((k == K_ILL) ? C_ILL : 18'b0), r));
      case (k)
         K_LW: begin
            q.push_back(mk(op, rbit(), 4'd2, C_ASA | f_asb(2'b10), r));
            for (int unsigned i = 0; i < w2; i++) q.push_back(mk(op, 1'b0, 4'd3, C_MRD | C_IORD, r));
            q.push_back(mk(op, 1'b1, 4'd3, C_MRD | C_IORD, r));
            q.push_back(mk(op, rbit(), 4'd4, C_RW | C_M2R, r));
         end
         K_SW: begin
            q.push_back(mk(op, rbit(), 4'd2, C_ASA | f_asb(2'b10), r));
            for (int unsigned i = 0; i < w2; i++) q.push_back(mk(op, 1'b0, 4'd5, C_MWR | C_IORD, r));
            q.push_back(mk(op, 1'b1, 4'd5, C_MWR | C_IORD, r));
         end
         K_R: begin
            q.push_back(mk(op, rbit(), 4'd6, C_ASA | f_aop(2'b10), r));
            q.push_back(mk(op, rbit(), 4'd7, C_RW | C_RD, r));
         end
         K_BEQ: q.push_back(mk(op, rbit(), 4'd8, C_ASA | f_aop(2'b01) | f_ps(2'b01) | C_PCC, r));
         K_BNE: q.push_back(mk(op, rbit(), 4'd8, C_ASA | f_aop(2'b01) | f_ps(2'b01) | C_PCN, r));
         K_J:   q.push_back(mk(op, rbit(), 4'd9, C_PCW | f_ps(2'b10), r));
         K_ADDI: begin
            q.push_back(mk(op, rbit(), 4'd10, C_ASA | f_asb(2'b10), r));
            q.push_back(mk(op, rbit(), 4'd11, C_RW, r));
         end
         default: ;
      endcase
      n = (cut != 0) ? cut : q.size();
      for (int unsigned i = 0; i < n; i++) begin
         @(negedge clk);
         drive(sel, q[i].op, q[i].mr);
         #1;
         compare(sel, q[i], $sformatf("%s.op%02h.c%0d", sel == 0 ? "A" : "B", op, i));
      end
      if (cut == 0 && k != K_ILL) ret_m[sel] = ret_m[sel] + 1;
   endtask

   task automatic run_random(input int sel, input int count);
      logic [5:0] op;
      for (int i = 0; i < count; i++) begin
         case ($urandom_range(0, 8))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_BEQ;
            4: op = OP_BNE;
            5: op = OP_J;
            6: op = OP_ADDI;
            default: op = rop();
         endcase
         run_instr(sel, op, $urandom_range(0, 3), $urandom_range(0, 3), 0);
      end
   endtask

   initial begin
      ret_m[0] = 0;
      ret_m[1] = 0;

      do_reset(0);
      run_instr(0, OP_LW, 2, 1, 0);
      run_instr(0, OP_R, 0, 0, 0);
      run_instr(0, OP_SW, 0, 0, 0);
      run_instr(0, OP_BEQ, 0, 0, 0);
      run_instr(0, OP_BNE, 0, 0, 0);
      run_instr(0, OP_ADDI, 0, 0, 0);
      run_instr(0, OP_J, 0, 0, 0);
      run_instr(0, 6'b111111, 1, 0, 0);
      run_random(0, 80);
      run_instr(0, OP_LW, 1, 3, 6);
      do_reset(0);
      run_instr(0, OP_LW, 0, 0, 0);
      run_random(0, 10);

      do_reset(1);
      run_instr(1, OP_BNE, 0, 0, 0);
      run_instr(1, OP_ADDI, 1, 0, 0);
      for (int i = 0; i < 16; i++) run_instr(1, OP_J, 0, 0, 0);
      run_random(1, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/mc_ctrl_seq.md
# mc_ctrl_seq

Registered multicycle MIPS control unit: holds its own 4-bit state register, decodes the opcode latched in IR, and drives every datapath control line as a Moore function of state. Generalises the combinational controller with a memory-ready handshake (wait states), optional ADDI/BNE support, illegal-opcode detection and a retired-instruction counter. Sits between the IR/memory interface and the multicycle datapath.

## Interface

- CNT_W, 32, width of retired-instruction counter
- EN_IMM, 1, 1 = ADDI (opcode 001000) supported; 0 = treated as illegal
- EN_BNE, 1, 1 = BNE (opcode 000101) supported; 0 = treated as illegal

- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26], stable from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write, pc_write_cond, pc_write_cond_ne  out  1  PC unconditional / on zero / on not-zero
- iord, mem_read, mem_write, ir_write, mem_to_reg, alu_src_a, reg_write, reg_dst  out  1  datapath controls
- pc_source  out  2  00 ALU, 01 ALUOut, 10 jump target
- alu_op  out  2  00 add, 01 sub, 10 funct field
- alu_src_b  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm
- state  out  4  current state
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- retired  out  CNT_W  instructions completed, wraps

## Operation

- States: IDLE=15, FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11. Encodings 12-14 unused; if reached, next state FETCH, all outputs 0.
- IDLE: all outputs 0; next FETCH.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00; ir_write=pc_write=mem_ready. Stay while mem_ready=0; DECODE when 1.
- DECODE: alu_src_b=11. Next: lw/sw (100011/101011) MEMADR; R-type (000000) EXEC; beq (000100) or enabled bne BRANCH; j (000010) JUMP; enabled addi IEXEC; else FETCH with illegal_op=1.
- MEMADR: alu_src_a=1, alu_src_b=10. lw MEMRD, sw MEMWR.
- MEMRD: mem_read=1, iord=1; hold until mem_ready, then MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1; next FETCH.
- MEMWR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_op=10; next RWB. RWB: reg_write=1, reg_dst=1; next FETCH.
- BRANCH: alu_src_a=1, alu_op=01, pc_source=01; pc_write_cond=1 for beq, pc_write_cond_ne=1 for bne (never both); next FETCH.
- JUMP: pc_write=1, pc_source=10; next FETCH.
- IEXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
- retired increments by 1 on the clock edge leaving MEMWB, RWB, BRANCH, JUMP, IWB, and MEMWR with mem_ready=1; modulo 2^CNT_W. Illegal opcodes not counted.
- Outputs not listed for a state are 0.

## Timing

- Reset asserted: state=IDLE, retired=0, illegal_op=0, every control output 0, immediately (asynchronous).
- Reset deasserted: first edge IDLE->FETCH; no memory access during or one cycle after reset.
- Zero-wait latencies (FETCH to next FETCH): lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal 2 cycles. Each wait cycle (mem_ready=0 in FETCH/MEMRD/MEMWR) adds one.
- mem_read/mem_write held constant through wait cycles; mem_ready ignored in all other states.
- illegal_op is combinational from DECODE + opcode, high exactly one cycle.
- Reset mid-instruction (any state, including wait): aborts, no further writes, retired cleared.

## Test plan

- lw (100011), mem_ready low 2 cycles in FETCH and 1 in MEMRD -> states 15,0,0,0,1,2,3,3,4,0; ir_write high only on 3rd FETCH cycle; retired 0->1.
- R-type then sw, mem_ready tied 1 -> 0,1,6,7,0,1,2,5,0; reg_dst=1 only in RWB; retired=2.
- beq then bne (EN_BNE=1) -> BRANCH with pc_write_cond=1/ne=0, then 0/1; alu_op=01 both.
- EN_BNE=0, EN_IMM=0, opcodes 000101 and 001000 -> DECODE->FETCH, illegal_op one-cycle pulse each, retired unchanged.
- reset_n low during MEMRD wait -> outputs 0 same cycle, state 15, retired 0; release -> FETCH next edge.
- CNT_W=4, 16 j instructions -> retired 15 wraps to 0 on 16th completion.
